// File: rtl/vga_pkg.sv
// Shared constants, write-FSM encoding and picture address mapping for the VGA
// picture memory; the read-side bit generator uses the same pic_addr().
package vga_pkg;

  localparam int ROW_WORDS = 6;
  localparam int PIC_ROWS  = 16;
  localparam int PIC_WORDS = ROW_WORDS * PIC_ROWS;
  localparam int NUM_PICS  = 42;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 9;
  localparam int PIC_W     = 10;
  localparam int Y_W       = 4;
  localparam int X_W       = 3;
  localparam int CNT_W     = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FILL  = 2'd2
  } wr_state_t;

  typedef struct packed {
    logic [PIC_W-1:0]  pic;
    logic [Y_W-1:0]    y;
    logic [X_W-1:0]    x;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // pic*96 + y*6 + x from shifts and adds only; the sum wraps at ADDR_W bits
  function automatic logic [ADDR_W-1:0] pic_addr(
    input logic [PIC_W-1:0] pic,
    input logic [Y_W-1:0]   y,
    input logic [X_W-1:0]   x
  );
    logic [ADDR_W-1:0] w_p;
    logic [ADDR_W-1:0] w_y;
    w_p = ADDR_W'(pic);
    w_y = ADDR_W'(y);
    return (w_p << 6) + (w_p << 5) + (w_y << 2) + (w_y << 1) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/vga_req_fifo.sv
// Synchronous request FIFO for the picture writer; full/empty/count flags are
// derived from a registered occupancy counter.
module vga_req_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  wr_req_t                i_din,
  output wr_req_t                o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wr_req_t       r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == {(AW+1){1'b0}});
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vga_pic_writer.sv
// Write-side front end for the VGA picture memory: buffered host word writes
// plus whole-picture hardware fill. Range checks and err under VGA_PIC_WR_BOUNDS_EN.
module vga_pic_writer
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PIC_W-1:0]  req_pic,
  input  logic [X_W-1:0]    req_x,
  input  logic [Y_W-1:0]    req_y,
  input  logic [DATA_W-1:0] req_data,
  input  logic              fill_start,
  input  logic [PIC_W-1:0]  fill_pic,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              err_clr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wr_state_t         r_state;
  wr_state_t         w_state_nx;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_fill_base;
  logic [DATA_W-1:0] r_fill_data;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_err;

  wr_req_t           w_din;
  wr_req_t           w_head;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic              w_push;
  logic              w_pop;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_fill_go;
  logic              w_err_set;
  logic              w_req_ok;
  logic              w_fill_ok;

  assign req_ready = !w_full;
  assign w_push    = req_valid && !w_full;
  assign w_din     = '{pic: req_pic, y: req_y, x: req_x, data: req_data};

  vga_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

`ifdef VGA_PIC_WR_BOUNDS_EN
  assign w_req_ok  = (w_head.pic < PIC_W'(NUM_PICS)) && (w_head.x < X_W'(ROW_WORDS));
  assign w_fill_ok = (fill_pic < PIC_W'(NUM_PICS));
`else
  assign w_req_ok  = 1'b1;
  assign w_fill_ok = 1'b1;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_we       = 1'b0;
    w_addr     = r_mem_addr;
    w_wdata    = r_mem_wdata;
    w_fill_go  = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fill_start && w_fill_ok) begin
          w_fill_go  = 1'b1;
          w_state_nx = ST_FILL;
        end else if (!w_empty || w_push) begin
          w_state_nx = ST_DRAIN;
        end else begin
          w_state_nx = ST_IDLE;
        end
        w_err_set = fill_start && !w_fill_ok;
      end
      ST_DRAIN: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_req_ok) begin
            w_we    = 1'b1;
            w_addr  = pic_addr(w_head.pic, w_head.y, w_head.x);
            w_wdata = w_head.data;
          end else begin
            w_err_set = 1'b1;
          end
        end
        // Leave only once this pop empties the FIFO and nothing new arrives.
        if ((w_empty || (w_count == CW'(1))) && !w_push) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_state_nx = ST_DRAIN;
        end
      end
      ST_FILL: begin
        w_we    = 1'b1;
        w_addr  = r_fill_base + ADDR_W'(r_cnt);
        w_wdata = r_fill_data;
        if (r_cnt == CNT_W'(PIC_WORDS - 1)) begin
          w_state_nx = (!w_empty || w_push) ? ST_DRAIN : ST_IDLE;
        end else begin
          w_state_nx = ST_FILL;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_fill_base <= '0;
      r_fill_data <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_mem_we    <= w_we;
      r_mem_addr  <= w_addr;
      r_mem_wdata <= w_wdata;
      if (w_fill_go) begin
        r_cnt       <= '0;
        r_fill_base <= pic_addr(fill_pic, 4'd0, 3'd0);
        r_fill_data <= fill_data;
      end else if (r_state == ST_FILL) begin
        r_cnt <= r_cnt + 7'd1;
      end
      r_err <= err_clr ? 1'b0 : (r_err | w_err_set);
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign err       = r_err;
  assign busy      = !w_empty || (r_state != ST_IDLE) || r_mem_we;

endmodule
